// File: rtl/core_types_pkg.sv
// Shared constants and types for the pending-request tracker slice.
package core_types_pkg;

    localparam int PQ_WIDTH_DEF = 8;
    localparam int CNT_W        = 4;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        SLOT_IDLE   = 2'd0,
        SLOT_WAIT   = 2'd1,
        SLOT_URGENT = 2'd2
    } slot_state_e;

endpackage

// File: rtl/pq_req_slot.sv
// One request slot: pending/urgent state plus a 4-bit saturating wait counter.
module pq_req_slot
    import core_types_pkg::*;
#(
    parameter int STARVE_THRESH = 12
) (
    input  logic CLK,
    input  logic RST,
    input  logic set_i,
    input  logic ack_i,
    input  logic flush_i,
    output logic pend_o,
    output logic pend_next_o,
    output logic urgent_o
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STARVE_THRESH);

    slot_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q;

    assign pend_q = (state_q != SLOT_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = SLOT_IDLE;
            cnt_d   = '0;
        end else if (!pend_q || ack_i) begin
            // A set on the same cycle as the ack keeps the slot but restarts its wait.
            state_d = set_i ? SLOT_WAIT : SLOT_IDLE;
            cnt_d   = '0;
        end else begin
            if (!set_i && cnt_q != CNT_MAX)
                cnt_d = cnt_q + CNT_W'(1);
            state_d = (cnt_d >= THRESH_C) ? SLOT_URGENT : SLOT_WAIT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= SLOT_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pend_o      = pend_q;
    assign pend_next_o = (state_d != SLOT_IDLE);
    assign urgent_o    = (state_q == SLOT_URGENT);

endmodule

// File: rtl/pq_req_tracker.sv
// Tracks pending request slots for an LSB priority encoder, flags starving
// slots, and reports acks to idle slots and drain-to-empty events.
module pq_req_tracker
    import core_types_pkg::*;
#(
    parameter int WIDTH         = PQ_WIDTH_DEF,
    parameter int STARVE_THRESH = 12
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         set_vec,
    input  logic                     flush,
    input  logic                     ack_valid,
    input  logic [$clog2(WIDTH)-1:0] ack_index,
    output logic [WIDTH-1:0]         req_vec,
    output logic [WIDTH-1:0]         urgent_vec,
    output logic [WIDTH-1:0]         ack_one_hot,
    output logic                     ack_err,
    output logic                     all_clear
);

    logic [WIDTH-1:0] pend_next;
    logic             ack_err_q, ack_err_d;
    logic             all_clear_q, all_clear_d;

    always_comb begin
        ack_one_hot = '0;
        if (ack_valid)
            ack_one_hot[ack_index] = 1'b1;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_slot
        pq_req_slot #(
            .STARVE_THRESH (STARVE_THRESH)
        ) u_slot (
            .CLK         (CLK),
            .RST         (RST),
            .set_i       (set_vec[i]),
            .ack_i       (ack_one_hot[i]),
            .flush_i     (flush),
            .pend_o      (req_vec[i]),
            .pend_next_o (pend_next[i]),
            .urgent_o    (urgent_vec[i])
        );
    end

    // An ack to an idle slot is an error even if the same slot is being set now.
    always_comb begin
        ack_err_d   = ack_valid && !req_vec[ack_index] && !flush;
        all_clear_d = (|req_vec) && !(|pend_next);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ack_err_q   <= 1'b0;
            all_clear_q <= 1'b0;
        end else begin
            ack_err_q   <= ack_err_d;
            all_clear_q <= all_clear_d;
        end
    end

    assign ack_err   = ack_err_q;
    assign all_clear = all_clear_q;

endmodule

// File: tb/tb_pq_req_tracker.sv
// Directed scenarios plus a randomized run against a slot-level reference model.
module tb_pq_req_tracker;

    localparam int W  = 8;
    localparam int TH = 12;

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] set_vec;
    logic         flush;
    logic         ack_valid;
    logic [2:0]   ack_index;
    logic [W-1:0] req_vec;
    logic [W-1:0] urgent_vec;
    logic [W-1:0] ack_one_hot;
    logic         ack_err;
    logic         all_clear;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per-slot pending flag and wait age in cycles.
    int m_pend [W];
    int m_age  [W];
    int m_err;
    int m_clr;

    pq_req_tracker #(
        .WIDTH         (W),
        .STARVE_THRESH (TH)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .set_vec     (set_vec),
        .flush       (flush),
        .ack_valid   (ack_valid),
        .ack_index   (ack_index),
        .req_vec     (req_vec),
        .urgent_vec  (urgent_vec),
        .ack_one_hot (ack_one_hot),
        .ack_err     (ack_err),
        .all_clear   (all_clear)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        set_vec   = '0;
        flush     = 1'b0;
        ack_valid = 1'b0;
        ack_index = '0;
    endtask

    // Emulates the LSB priority encoder that normally sits on req_vec.
    function automatic logic [2:0] lsb_idx(input logic [W-1:0] x);
        logic [2:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--)
            if (x[i]) r = 3'(i);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < W; i++) begin
            m_pend[i] = 0;
            m_age[i]  = 0;
        end
        m_err = 0;
        m_clr = 0;
    endtask

    task automatic model_step(input logic [W-1:0] sv, input logic av,
                              input int idx, input logic fl);
        int any_old;
        int any_new;
        any_old = 0;
        any_new = 0;
        for (int i = 0; i < W; i++) if (m_pend[i] != 0) any_old = 1;
        m_err = (av && m_pend[idx] == 0 && !fl) ? 1 : 0;
        for (int i = 0; i < W; i++) begin
            if (fl) begin
                m_pend[i] = 0;
                m_age[i]  = 0;
            end else if (m_pend[i] == 0 || (av && idx == i)) begin
                m_pend[i] = sv[i] ? 1 : 0;
                m_age[i]  = 0;
            end else if (!sv[i]) begin
                m_age[i] = (m_age[i] >= 15) ? 15 : m_age[i] + 1;
            end
            if (m_pend[i] != 0) any_new = 1;
        end
        m_clr = (any_old != 0 && any_new == 0) ? 1 : 0;
    endtask

    task automatic test_reset();
        RST = 1'b1; set_vec = 8'hFF; flush = 1'b0; ack_valid = 1'b0; ack_index = '0;
        cycle(); cycle();
        n_checks++; if (req_vec !== 8'h00) $display("FAIL reset_req: got %h expected 00", req_vec); else n_pass++;
        n_checks++; if (urgent_vec !== 8'h00) $display("FAIL reset_urgent: got %h expected 00", urgent_vec); else n_pass++;
        n_checks++; if (ack_err !== 1'b0) $display("FAIL reset_ack_err: got %b expected 0", ack_err); else n_pass++;
        n_checks++; if (all_clear !== 1'b0) $display("FAIL reset_all_clear: got %b expected 0", all_clear); else n_pass++;
        ack_valid = 1'b1; ack_index = 3'd3; #1;
        n_checks++; if (ack_one_hot !== 8'h08) $display("FAIL reset_onehot: got %h expected 08", ack_one_hot); else n_pass++;
        ack_valid = 1'b0; #1;
        n_checks++; if (ack_one_hot !== 8'h00) $display("FAIL reset_onehot_off: got %h expected 00", ack_one_hot); else n_pass++;
        RST = 1'b0; idle_inputs();
        cycle();
        n_checks++; if (all_clear !== 1'b0) $display("FAIL reset_release_clr: got %b expected 0", all_clear); else n_pass++;
    endtask

    task automatic test_set_ack();
        set_vec = 8'b0001_0110;
        cycle();
        n_checks++; if (req_vec !== 8'h16) $display("FAIL set_ack_req0: got %h expected 16", req_vec); else n_pass++;
        set_vec = '0; ack_valid = 1'b1; ack_index = 3'd1;
        cycle();
        n_checks++; if (req_vec !== 8'h14) $display("FAIL set_ack_req1: got %h expected 14", req_vec); else n_pass++;
        n_checks++; if (ack_err !== 1'b0) $display("FAIL set_ack_err: got %b expected 0", ack_err); else n_pass++;
        ack_index = 3'd2;
        cycle();
        n_checks++; if (req_vec !== 8'h10) $display("FAIL set_ack_req2: got %h expected 10", req_vec); else n_pass++;
        n_checks++; if (all_clear !== 1'b0) $display("FAIL set_ack_clr_early: got %b expected 0", all_clear); else n_pass++;
        ack_index = 3'd4;
        cycle();
        n_checks++; if (req_vec !== 8'h00) $display("FAIL set_ack_req3: got %h expected 00", req_vec); else n_pass++;
        n_checks++; if (all_clear !== 1'b1) $display("FAIL set_ack_clr: got %b expected 1", all_clear); else n_pass++;
        idle_inputs();
        cycle();
        n_checks++; if (all_clear !== 1'b0) $display("FAIL set_ack_clr_pulse: got %b expected 0", all_clear); else n_pass++;
    endtask

    task automatic test_collision();
        logic exp_u;
        set_vec = 8'h08;
        cycle();
        set_vec = '0;
        repeat (5) cycle();
        set_vec = 8'h08; ack_valid = 1'b1; ack_index = 3'd3;
        cycle();
        n_checks++; if (req_vec !== 8'h08) $display("FAIL coll_req: got %h expected 08", req_vec); else n_pass++;
        n_checks++; if (ack_err !== 1'b0) $display("FAIL coll_err: got %b expected 0", ack_err); else n_pass++;
        idle_inputs();
        // Counter restarted at 0, so urgency appears exactly TH cycles later.
        for (int k = 1; k <= TH; k++) begin
            cycle();
            exp_u = (k >= TH);
            n_checks++;
            if (urgent_vec[3] !== exp_u)
                $display("FAIL coll_urgent_k%0d: got %b expected %b", k, urgent_vec[3], exp_u);
            else n_pass++;
        end
        ack_valid = 1'b1; ack_index = 3'd3;
        cycle();
        n_checks++; if (req_vec !== 8'h00) $display("FAIL coll_ack_req: got %h expected 00", req_vec); else n_pass++;
        n_checks++; if (urgent_vec !== 8'h00) $display("FAIL coll_ack_urg: got %h expected 00", urgent_vec); else n_pass++;
        idle_inputs();
        cycle();
    endtask

    task automatic test_starvation();
        logic exp_u;
        set_vec = 8'h01;
        cycle();
        n_checks++; if (req_vec !== 8'h01) $display("FAIL starve_req: got %h expected 01", req_vec); else n_pass++;
        set_vec = '0;
        for (int k = 1; k <= TH; k++) begin
            cycle();
            exp_u = (k >= TH);
            n_checks++;
            if (urgent_vec[0] !== exp_u)
                $display("FAIL starve_urgent_k%0d: got %b expected %b", k, urgent_vec[0], exp_u);
            else n_pass++;
        end
        for (int k = 0; k < 20; k++) begin
            cycle();
            n_checks++;
            if (urgent_vec !== 8'h01)
                $display("FAIL starve_saturate_k%0d: got %h expected 01", k, urgent_vec);
            else n_pass++;
        end
        ack_valid = 1'b1; ack_index = 3'd0;
        cycle();
        n_checks++; if (req_vec !== 8'h00) $display("FAIL starve_ack_req: got %h expected 00", req_vec); else n_pass++;
        n_checks++; if (urgent_vec !== 8'h00) $display("FAIL starve_ack_urg: got %h expected 00", urgent_vec); else n_pass++;
        n_checks++; if (all_clear !== 1'b1) $display("FAIL starve_ack_clr: got %b expected 1", all_clear); else n_pass++;
        idle_inputs();
        cycle();
    endtask

    task automatic test_error_flush();
        set_vec = 8'h01;
        cycle();
        set_vec = '0; ack_valid = 1'b1; ack_index = 3'd5;
        cycle();
        n_checks++; if (ack_err !== 1'b1) $display("FAIL err_pulse: got %b expected 1", ack_err); else n_pass++;
        n_checks++; if (req_vec !== 8'h01) $display("FAIL err_req: got %h expected 01", req_vec); else n_pass++;
        ack_valid = 1'b0;
        cycle();
        n_checks++; if (ack_err !== 1'b0) $display("FAIL err_one_cycle: got %b expected 0", ack_err); else n_pass++;
        set_vec = 8'h40; ack_valid = 1'b1; ack_index = 3'd6;
        cycle();
        n_checks++; if (ack_err !== 1'b1) $display("FAIL err_with_set: got %b expected 1", ack_err); else n_pass++;
        n_checks++; if (req_vec !== 8'h41) $display("FAIL err_with_set_req: got %h expected 41", req_vec); else n_pass++;
        idle_inputs(); flush = 1'b1;
        cycle();
        n_checks++; if (req_vec !== 8'h00) $display("FAIL flush1_req: got %h expected 00", req_vec); else n_pass++;
        n_checks++; if (all_clear !== 1'b1) $display("FAIL flush1_clr: got %b expected 1", all_clear); else n_pass++;
        flush = 1'b0; set_vec = 8'hA5;
        cycle();
        n_checks++; if (req_vec !== 8'hA5) $display("FAIL flush_pre_req: got %h expected A5", req_vec); else n_pass++;
        set_vec = '0;
        repeat (TH) cycle();
        n_checks++; if (urgent_vec !== 8'hA5) $display("FAIL flush_pre_urg: got %h expected A5", urgent_vec); else n_pass++;
        flush = 1'b1; set_vec = 8'hFF; ack_valid = 1'b1; ack_index = 3'd1;
        cycle();
        n_checks++; if (req_vec !== 8'h00) $display("FAIL flush_req: got %h expected 00", req_vec); else n_pass++;
        n_checks++; if (urgent_vec !== 8'h00) $display("FAIL flush_urg: got %h expected 00", urgent_vec); else n_pass++;
        n_checks++; if (all_clear !== 1'b1) $display("FAIL flush_clr: got %b expected 1", all_clear); else n_pass++;
        n_checks++; if (ack_err !== 1'b0) $display("FAIL flush_err: got %b expected 0", ack_err); else n_pass++;
        idle_inputs();
        cycle();
        n_checks++; if (all_clear !== 1'b0) $display("FAIL flush_clr_idle: got %b expected 0", all_clear); else n_pass++;
    endtask

    task automatic test_reset_mid();
        set_vec = 8'h0F;
        cycle();
        n_checks++; if (req_vec !== 8'h0F) $display("FAIL rstmid_pre: got %h expected 0F", req_vec); else n_pass++;
        RST = 1'b1; flush = 1'b1; set_vec = 8'hF0; ack_valid = 1'b1; ack_index = 3'd6;
        cycle();
        n_checks++; if (req_vec !== 8'h00) $display("FAIL rstmid_req: got %h expected 00", req_vec); else n_pass++;
        n_checks++; if (all_clear !== 1'b0) $display("FAIL rstmid_clr: got %b expected 0", all_clear); else n_pass++;
        n_checks++; if (ack_err !== 1'b0) $display("FAIL rstmid_err: got %b expected 0", ack_err); else n_pass++;
        RST = 1'b0; idle_inputs();
        cycle();
        n_checks++; if (req_vec !== 8'h00) $display("FAIL rstmid_post_req: got %h expected 00", req_vec); else n_pass++;
        n_checks++; if (all_clear !== 1'b0) $display("FAIL rstmid_post_clr: got %b expected 0", all_clear); else n_pass++;
    endtask

    task automatic test_closed_loop();
        logic [W-1:0] exp_r;
        logic [W-1:0] exp_oh;
        int           pop;
        idle_inputs();
        for (int v = 0; v < 256; v++) begin
            set_vec = 8'(v); ack_valid = 1'b0;
            cycle();
            set_vec = '0;
            exp_r = 8'(v);
            pop = $countones(exp_r);
            n_checks++;
            if (req_vec !== exp_r) $display("FAIL loop_v%0d_first: got %h expected %h", v, req_vec, exp_r);
            else n_pass++;
            for (int k = 0; k < pop; k++) begin
                ack_valid = |req_vec;
                ack_index = lsb_idx(req_vec);
                #1;
                exp_oh = exp_r & (~exp_r + 8'd1);
                n_checks++;
                if (ack_one_hot !== exp_oh)
                    $display("FAIL loop_v%0d_ack%0d: got %h expected %h", v, k, ack_one_hot, exp_oh);
                else n_pass++;
                cycle();
                exp_r = exp_r & ~exp_oh;
                n_checks++;
                if (req_vec !== exp_r)
                    $display("FAIL loop_v%0d_step%0d: got %h expected %h", v, k, req_vec, exp_r);
                else n_pass++;
            end
            n_checks++;
            if (all_clear !== (v != 0))
                $display("FAIL loop_v%0d_clr: got %b expected %b", v, all_clear, (v != 0));
            else n_pass++;
            ack_valid = 1'b0;
        end
        cycle();
    endtask

    task automatic test_random();
        logic [W-1:0] sv;
        logic         av;
        logic         fl;
        int           idx;
        logic [W-1:0] exp_req;
        logic [W-1:0] exp_urg;
        logic [W-1:0] exp_oh;
        idle_inputs(); flush = 1'b1;
        cycle();
        flush = 1'b0;
        model_clear();
        for (int c = 0; c < 500; c++) begin
            sv  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            av  = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, W - 1);
            fl  = ($urandom_range(0, 39) == 0);
            set_vec = sv; ack_valid = av; ack_index = 3'(idx); flush = fl;
            #1;
            exp_oh = av ? 8'(1 << idx) : 8'h00;
            n_checks++;
            if (ack_one_hot !== exp_oh) $display("FAIL rand_c%0d_onehot: got %h expected %h", c, ack_one_hot, exp_oh);
            else n_pass++;
            model_step(sv, av, idx, fl);
            cycle();
            for (int i = 0; i < W; i++) begin
                exp_req[i] = (m_pend[i] != 0);
                exp_urg[i] = (m_pend[i] != 0) && (m_age[i] >= TH);
            end
            n_checks++;
            if (req_vec !== exp_req) $display("FAIL rand_c%0d_req: got %h expected %h", c, req_vec, exp_req);
            else n_pass++;
            n_checks++;
            if (urgent_vec !== exp_urg) $display("FAIL rand_c%0d_urg: got %h expected %h", c, urgent_vec, exp_urg);
            else n_pass++;
            n_checks++;
            if (ack_err !== (m_err != 0)) $display("FAIL rand_c%0d_err: got %b expected %0d", c, ack_err, m_err);
            else n_pass++;
            n_checks++;
            if (all_clear !== (m_clr != 0)) $display("FAIL rand_c%0d_clr: got %b expected %0d", c, all_clear, m_clr);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;
        test_reset();
        test_set_ack();
        test_collision();
        test_starvation();
        test_error_flush();
        test_reset_mid();
        test_closed_loop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pq_req_tracker.md
PQ_REQ_TRACKER -- requirements
Module: pq_req_tracker

Interface
REQ-001 Parameter: WIDTH, default 8, number of request slots; SHALL be a power of two, at least 2.
REQ-002 Parameter: STARVE_THRESH, default 12, wait-cycle count at which a pending slot becomes urgent; SHALL be in the range 1..15.
REQ-003 Ports SHALL be: CLK  input  1  sole clock; all state updates on posedge.
REQ-004 RST  input  1  reset, synchronous, active-high (already decided).
REQ-005 set_vec  input  WIDTH  multi-hot new requests; each set bit marks that slot pending.
REQ-006 flush  input  1  clears all pending slots and all counters.
REQ-007 ack_valid  input  1  qualifies ack_index.
REQ-008 ack_index  input  $clog2(WIDTH)  encoded index of the granted slot, as produced by the LSB priority encoder.
REQ-009 req_vec  output  WIDTH  registered pending-slot vector; drives the encoder's req_vec.
REQ-010 urgent_vec  output  WIDTH  registered; pending slots whose wait counter is at or above STARVE_THRESH.
REQ-011 ack_one_hot  output  WIDTH  combinational decode of ack_index, gated by ack_valid.
REQ-012 ack_err  output  1  registered one-cycle pulse; the previous cycle's valid ack targeted a non-pending slot.
REQ-013 all_clear  output  1  registered one-cycle pulse when req_vec goes from nonzero to zero.

Function
REQ-014 ack_one_hot SHALL equal (1 << ack_index) when ack_valid=1, and all zeros otherwise.
REQ-015 Next pending state SHALL be (pending & ~ack_one_hot) | set_vec, so a set wins over a same-cycle ack to the same slot.
REQ-016 flush=1 SHALL force next pending to zero and zero all counters, overriding set_vec and the ack.
REQ-017 flush=1 SHALL suppress ack_err in the same cycle.
REQ-018 flush=1 SHALL still produce an all_clear pulse if req_vec was nonzero.
REQ-019 Latency: a set or ack on cycle N SHALL be visible on req_vec at cycle N+1; there is no combinational input-to-req_vec path.
REQ-020 Each slot SHALL have a 4-bit saturating wait counter.
REQ-021 Wait counter, cleared: when the slot is not pending, or is acked, or is newly set while not pending.
REQ-022 Wait counter, held: when a set hits an already-pending slot that is not being acked (no restart).
REQ-023 Wait counter, incremented by 1: when the slot is pending and not acked; it saturates at 15.
REQ-024 A set and an ack on the same pending slot in the same cycle SHALL leave it pending with its counter cleared.
REQ-025 urgent_vec[i] SHALL be registered, equal to pending_next[i] & (counter_next[i] >= STARVE_THRESH).
REQ-026 ack_err SHALL pulse on cycle N+1 when ack_valid=1 on cycle N and req_vec[ack_index]=0 on cycle N, regardless of set_vec; pending state is unchanged by such an ack.
REQ-027 all_clear SHALL pulse only on a nonzero-to-zero transition; it SHALL NOT pulse while req_vec stays zero.
REQ-028 Slot states are IDLE (not pending), WAIT (pending, counter below STARVE_THRESH) and URGENT (pending, counter at or above STARVE_THRESH).
REQ-029 URGENT SHALL be left only through an ack (go to IDLE, or to WAIT if re-set in the same cycle), a flush or a reset.

Reset
REQ-030 While RST=1 at a posedge, the block SHALL set req_vec, urgent_vec, all counters, ack_err and all_clear to 0.
REQ-031 RST SHALL override flush, set_vec and the ack.
REQ-032 Reset asserted mid-operation SHALL NOT produce an all_clear or ack_err pulse.
REQ-033 ack_one_hot is combinational and SHALL follow ack_index and ack_valid during reset.

Structure
REQ-034 The default slot count and the 4-bit wait-counter width SHALL be constants in core_types_pkg; STARVE_THRESH stays a module parameter.
REQ-035 The per-slot pending bit and counter SHALL be one sub-module, pq_req_slot, instantiated WIDTH times through a generate loop.
REQ-036 The index decode, ack_err and all_clear logic SHALL be at the top level.

Verification
REQ-037 Reset: hold RST=1 with set_vec=8'hFF and ack_valid=0 -> req_vec=0, urgent_vec=0, ack_err=0, all_clear=0.
REQ-038 Set and ack: set_vec=8'b00010110 at cycle 0; ack_index=1 at cycle 1 -> req_vec=00010110 at cycle 1 and 00010100 at cycle 2.
REQ-039 Set and ack: acks to 2 then 4 -> req_vec=0 and all_clear=1 on the cycle after the last ack.
REQ-040 Set-wins collision: slot 3 pending and counter=5; set_vec[3]=1 with ack_index=3 -> req_vec[3]=1 and counter=0 next cycle.
REQ-041 Starvation: set slot 0 and never ack it -> urgent_vec[0]=1 exactly 12 cycles after req_vec[0] rises; counter stays at 15 after saturation; an ack returns slot 0 to IDLE.
REQ-042 Error and flush: ack_index=5 with slot 5 idle -> ack_err=1 for one cycle and req_vec unchanged.
REQ-043 Error and flush: flush with req_vec=8'hA5 -> req_vec=0, all_clear=1 and urgent_vec=0.
REQ-044 Closed loop: drive every one of the 256 set_vec values, connect req_vec to a pq_lsb instance and feed its ack_index back with ack_valid=|req_vec -> slots are acked in ascending index order, one per cycle.
REQ-045 Closed loop: in the same test, req_vec SHALL reach 0 exactly popcount(set_vec) cycles after req_vec first holds the value.
